fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameters: PC_WIDTH, default 12, program-counter width; PMEM_ADDR_WIDTH, default 12, program-memory address width; PMEM_WORD_WIDTH, default 16, instruction word width; PC_INCREMENT, default 2, byte step per sequential fetch.
REQ-002 Ports, in order: clock  input  1  clock, rising-edge active.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_set_pc  input  1  redirect request from exec stage.
REQ-005 in_branch_pc  input  PMEM_ADDR_WIDTH  redirect target, valid while in_set_pc=1.
REQ-006 in_flush  input  1  kill the currently presented word and the in-flight word.
REQ-007 in_stall  input  1  decode cannot accept out_instr this cycle.
REQ-008 in_pmem_word  input  PMEM_WORD_WIDTH  program-memory read data, 1-cycle synchronous latency after out_pmem_addr.
REQ-009 out_pmem_addr  output  PMEM_ADDR_WIDTH  program-memory read address, combinational from internal state and in_stall.
REQ-010 out_instr  output  PMEM_WORD_WIDTH  instruction word to decode.
REQ-011 out_pc  output  PC_WIDTH  address of out_instr.
REQ-012 out_valid  output  1  out_instr/out_pc are a live instruction.

Function
REQ-013 Internal state: fetch_pc (address issued), resp_pc (address of word on in_pmem_word), resp_valid, FSM with states BOOT, RUN, REDIRECT.
REQ-014 Event priority per cycle: reset > in_set_pc > in_flush > in_stall > sequential advance.
REQ-015 BOOT: out_valid=0, out_pmem_addr=fetch_pc=0; next edge: fetch_pc<=PC_INCREMENT, resp_pc<=0, resp_valid<=1, state<=RUN.
REQ-016 RUN, no stall/flush/set_pc: out_pmem_addr=fetch_pc; edge: resp_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_INCREMENT, resp_valid<=1.
REQ-017 out_valid = resp_valid AND NOT in_flush AND state/=BOOT; out_instr = in_pmem_word when out_valid else 0; out_pc = resp_pc when out_valid else 0.
REQ-018 Stall (in_stall=1, out_valid=1): out_pmem_addr=resp_pc so the same word is re-read; fetch_pc, resp_pc, resp_valid held; out_instr/out_pc stable for every stall cycle.
REQ-019 in_stall while out_valid=0 is ignored; fetch advances per REQ-016.
REQ-020 in_set_pc=1 at edge N: fetch_pc<=in_branch_pc with bit 0 cleared, resp_valid<=0, state<=REDIRECT; out_pmem_addr=target in cycle N+1; first out_valid=1 with out_pc=target in cycle N+2.
REQ-021 REDIRECT: out_valid=0; in_stall ignored; edge: advance per REQ-016, state<=RUN, unless in_set_pc=1 again (restart REQ-020).
REQ-022 in_flush=1 without in_set_pc: out_valid=0 that cycle; edge: resp_valid<=0, fetch_pc unchanged (issue from fetch_pc resumes); state<=REDIRECT.
REQ-023 in_set_pc and in_stall in the same cycle: redirect wins, stalled word discarded.
REQ-024 Arithmetic: fetch_pc+PC_INCREMENT modulo 2^PC_WIDTH; 0xFFE -> 0x000, no flag.
REQ-025 out_pmem_addr = low PMEM_ADDR_WIDTH bits of the selected PC.

Reset
REQ-026 On reset=1, asynchronously: state=BOOT, fetch_pc=0, resp_pc=0, resp_valid=0; outputs out_valid=0, out_instr=0, out_pc=0, out_pmem_addr=0.
REQ-027 Reset asserted mid-stall or mid-redirect discards all pending state; first post-reset fetch is address 0.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN: when defined, port out_fetch_cnt output 16 increments on every edge where out_valid=1 and in_stall=0, saturates at 0xFFFF, resets to 0.
REQ-029 Without FETCH_PERF_CNT_EN: port and counter absent; all other behaviour identical.

Verification
REQ-030 Release reset, pmem model returns word=addr^0xA5A5, no stall -> out_valid low 1 cycle, then out_pc 0x000,0x002,0x004 with out_instr 0xA5A5,0xA5A7,0xA5A1.
REQ-031 in_stall=1 for 3 cycles while out_pc=0x004 -> out_pc/out_instr held 3 cycles, out_pmem_addr=0x004 during stall, next out_pc=0x006 after release.
REQ-032 in_set_pc=1, in_flush=1, in_branch_pc=0x120 at cycle N -> out_valid=0 in N and N+1, out_pc=0x120 valid at N+2, then 0x122.
REQ-033 in_set_pc=1 with in_branch_pc=0x121 -> out_pmem_addr=0x120, out_pc=0x120.
REQ-034 Redirect to 0xFFC, run 3 fetches -> out_pc 0xFFC,0xFFE,0x000.
REQ-035 Reset asserted during a stall -> outputs zero immediately; FETCH_PERF_CNT_EN build: out_fetch_cnt=0, then counts 1 per delivered non-stalled word.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: sequential fetch from a 1-cycle synchronous program memory,
// with stall replay, flush and branch redirect. Optional FETCH_PERF_CNT_EN adds a delivered-word counter.
module fetch #(
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PC_INCREMENT    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_set_pc,
  input  logic [PMEM_ADDR_WIDTH-1:0] in_branch_pc,
  input  logic                       in_flush,
  input  logic                       in_stall,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_word,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]                out_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [PC_WIDTH-1:0] respPc_q, respPc_d;
  logic                respValid_q, respValid_d;

  logic                outValid;
  logic                stallHold;
  logic [PC_WIDTH-1:0] branchPc;
  logic [PC_WIDTH-1:0] nextSeqPc;
  logic [PC_WIDTH-1:0] selPc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      fetchPc_q   <= '0;
      respPc_q    <= '0;
      respValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetchPc_q   <= fetchPc_d;
      respPc_q    <= respPc_d;
      respValid_q <= respValid_d;
    end
  end

  // BOOT needs no special branch: with fetchPc_q at zero, the sequential advance
  // produces exactly the boot transition.
  always_comb begin
    outValid    = respValid_q && !in_flush && (state_q != BOOT);
    stallHold   = in_stall && outValid;
    nextSeqPc   = fetchPc_q + PC_WIDTH'(PC_INCREMENT);
    branchPc    = PC_WIDTH'(in_branch_pc);
    branchPc[0] = 1'b0;

    state_d     = state_q;
    fetchPc_d   = fetchPc_q;
    respPc_d    = respPc_q;
    respValid_d = respValid_q;

    if (in_set_pc) begin
      fetchPc_d   = branchPc;
      respValid_d = 1'b0;
      state_d     = REDIRECT;
    end else if (in_flush) begin
      respValid_d = 1'b0;
      state_d     = REDIRECT;
    end else if (!stallHold) begin
      respPc_d    = fetchPc_q;
      fetchPc_d   = nextSeqPc;
      respValid_d = 1'b1;
      state_d     = RUN;
    end
  end

  // While stalled, re-read the presented word so it is still on the bus next cycle.
  always_comb begin
    selPc         = stallHold ? respPc_q : fetchPc_q;
    out_pmem_addr = PMEM_ADDR_WIDTH'(selPc);
    out_valid     = outValid;
    out_instr     = outValid ? in_pmem_word : '0;
    out_pc        = outValid ? respPc_q : '0;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetchCnt_q, fetchCnt_d;

  always_comb begin
    fetchCnt_d = fetchCnt_q;
    if (outValid && !in_stall && (fetchCnt_q != 16'hFFFF)) begin
      fetchCnt_d = fetchCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchCnt_q <= '0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
    end
  end

  assign out_fetch_cnt = fetchCnt_q;
`endif

endmodule
